// File: rtl/bus_xfer_pkg.sv
// Shared types and helpers for the bus transfer unit.
package bus_xfer_pkg;

   typedef enum logic [1:0] {
      OpMov = 2'b00,
      OpInc = 2'b01,
      OpDec = 2'b10,
      OpClr = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StLatch
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/bus_xfer_regbank.sv
// Register storage: transfer write port beats external write port, two read muxes.
// With BUS_XFER_ZERO_REG_EN defined, register 0 is hardwired to zero.
module bus_xfer_regbank
   import bus_xfer_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 8,
   localparam int unsigned SEL_W   = clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              xfer_we,
   input  logic [SEL_W-1:0]  xfer_sel,
   input  logic [DATA_W-1:0] xfer_data,
   input  logic              ext_we,
   input  logic [SEL_W-1:0]  ext_sel,
   input  logic [DATA_W-1:0] ext_data,
   input  logic [SEL_W-1:0]  rd_a_sel,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [SEL_W-1:0]  rd_b_sel,
   output logic [DATA_W-1:0] rd_b_data
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         // Out-of-range selects match no entry, so those writes fall away.
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (xfer_we && 32'(xfer_sel) == i) begin
               regs_q[i] <= xfer_data;
            end else if (ext_we && 32'(ext_sel) == i) begin
               regs_q[i] <= ext_data;
            end
         end
`ifdef BUS_XFER_ZERO_REG_EN
         regs_q[0] <= '0;
`endif
      end
   end

   always_comb begin
      rd_a_data = '0;
      if (32'(rd_a_sel) < NUM_REGS) rd_a_data = regs_q[rd_a_sel];
   end

   always_comb begin
      rd_b_data = '0;
      if (32'(rd_b_sel) < NUM_REGS) rd_b_data = regs_q[rd_b_sel];
   end

endmodule

// File: rtl/bus_xfer_unit.sv
// Register-to-register transfer unit: IDLE -> DRIVE -> LATCH with MOV/INC/DEC/CLR.
// Optional BUS_XFER_ZERO_REG_EN hardwires register 0 to zero (handled in the regbank).
module bus_xfer_unit
   import bus_xfer_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 8,
   localparam int unsigned SEL_W   = clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [SEL_W-1:0]  req_src,
   input  logic [SEL_W-1:0]  req_dst,
   input  logic [1:0]        req_op,
   input  logic              ext_wr_en,
   input  logic [SEL_W-1:0]  ext_wr_sel,
   input  logic [DATA_W-1:0] ext_wr_data,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] bus_data,
   output logic              done,
   output logic              carry,
   output logic              err
);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [SEL_W-1:0]  src_q, dst_q;
   logic [DATA_W-1:0] res_q, res_d, bus_val, src_data;
   logic              wrap_q, wrap_d, carry_q, err_q, err_d, accept;

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      done      = 1'b0;
      bus_val   = '0;
      res_d     = '0;
      wrap_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = ~rst;
            if (req_valid && !rst) state_d = StDrive;
         end
         StDrive: begin
            bus_val = (op_q == OpClr) ? '0 : src_data;
            state_d = StLatch;
         end
         StLatch: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      unique case (op_q)
         OpMov: res_d = bus_val;
         OpInc: begin
            res_d  = bus_val + DATA_W'(1);
            wrap_d = &bus_val;
         end
         OpDec: begin
            res_d  = bus_val - DATA_W'(1);
            wrap_d = ~|bus_val;
         end
         default: res_d = '0;
      endcase
   end

   assign accept = req_valid & req_ready;

   // Sticky: any out-of-range index seen on an accepted request or an external write.
   assign err_d = err_q
                | (accept && (32'(req_src) >= NUM_REGS || 32'(req_dst) >= NUM_REGS))
                | (ext_wr_en && 32'(ext_wr_sel) >= NUM_REGS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= OpMov;
         src_q   <= '0;
         dst_q   <= '0;
         res_q   <= '0;
         wrap_q  <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (accept) begin
            src_q <= req_src;
            dst_q <= req_dst;
            op_q  <= op_e'(req_op);
         end
         if (state_q == StDrive) begin
            res_q  <= res_d;
            wrap_q <= wrap_d;
         end
         if (state_q == StLatch && (op_q == OpInc || op_q == OpDec)) carry_q <= wrap_q;
      end
   end

   assign bus_data = bus_val;
   assign carry    = carry_q;
   assign err      = err_q;

   bus_xfer_regbank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regbank (
      .clk       (clk),
      .rst       (rst),
      .xfer_we   (state_q == StLatch),
      .xfer_sel  (dst_q),
      .xfer_data (res_q),
      .ext_we    (ext_wr_en),
      .ext_sel   (ext_wr_sel),
      .ext_data  (ext_wr_data),
      .rd_a_sel  (rd_sel),
      .rd_a_data (rd_data),
      .rd_b_sel  (src_q),
      .rd_b_data (src_data)
   );

endmodule

// File: tb/tb_bus_xfer_unit.sv
// Randomized and directed bench for bus_xfer_unit against a transaction-level model.
module tb_bus_xfer_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   // Main instance, default parameters.
   logic       a_req_valid = 1'b0, a_req_ready, a_ext_wr_en = 1'b0;
   logic [2:0] a_req_src = '0, a_req_dst = '0, a_ext_wr_sel = '0, a_rd_sel = '0;
   logic [1:0] a_req_op = '0;
   logic [7:0] a_ext_wr_data = '0, a_rd_data, a_bus_data;
   logic       a_done, a_carry, a_err;

   // Second instance with six registers for out-of-range indices.
   logic       b_req_valid = 1'b0, b_req_ready, b_ext_wr_en = 1'b0;
   logic [2:0] b_req_src = '0, b_req_dst = '0, b_ext_wr_sel = '0, b_rd_sel = '0;
   logic [1:0] b_req_op = '0;
   logic [7:0] b_ext_wr_data = '0, b_rd_data, b_bus_data;
   logic       b_done, b_carry, b_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m_regs [8];
   logic       m_carry;

   always #10 clk = ~clk;

   bus_xfer_unit dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_src(a_req_src), .req_dst(a_req_dst), .req_op(a_req_op),
      .ext_wr_en(a_ext_wr_en), .ext_wr_sel(a_ext_wr_sel), .ext_wr_data(a_ext_wr_data),
      .rd_sel(a_rd_sel), .rd_data(a_rd_data), .bus_data(a_bus_data),
      .done(a_done), .carry(a_carry), .err(a_err)
   );

   bus_xfer_unit #(.DATA_W(8), .NUM_REGS(6)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_src(b_req_src), .req_dst(b_req_dst), .req_op(b_req_op),
      .ext_wr_en(b_ext_wr_en), .ext_wr_sel(b_ext_wr_sel), .ext_wr_data(b_ext_wr_data),
      .rd_sel(b_rd_sel), .rd_data(b_rd_data), .bus_data(b_bus_data),
      .done(b_done), .carry(b_carry), .err(b_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_write(input int sel, input logic [7:0] data);
`ifdef BUS_XFER_ZERO_REG_EN
      if (sel != 0) m_regs[sel] = data;
`else
      m_regs[sel] = data;
`endif
   endtask

   task automatic check_all();
      for (int i = 0; i < 8; i++) begin
         a_rd_sel = 3'(i);
         #1;
         check_val($sformatf("reg%0d", i), a_rd_data, m_regs[i]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_val("rst_ready", a_req_ready, 0);
      check_val("rst_bus", a_bus_data, 0);
      check_val("rst_done", a_done, 0);
      @(posedge clk);
      #1;
      check_val("rst_ready_hold", a_req_ready, 0);
      rst = 1'b0;
      #1;
      check_val("ready_after_rst", a_req_ready, 1);
      check_val("carry_after_rst", a_carry, 0);
      check_val("err_after_rst", a_err, 0);
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_carry = 1'b0;
   endtask

   task automatic ext_write(input int sel, input logic [7:0] data);
      a_ext_wr_en   = 1'b1;
      a_ext_wr_sel  = 3'(sel);
      a_ext_wr_data = data;
      @(posedge clk);
      #1;
      a_ext_wr_en = 1'b0;
      model_write(sel, data);
   endtask

   // k selects the cycle of a concurrent external write: 0 accept, 1 drive, 2 latch, 3 none.
   task automatic xfer(input int src, input int dst, input int op, input int k,
                       input int esel, input logic [7:0] edata, input bit junk);
      logic [7:0] sv, bus_exp, res;
      logic       wrap;
      check_val("ready_idle", a_req_ready, 1);
      a_req_valid   = 1'b1;
      a_req_src     = 3'(src);
      a_req_dst     = 3'(dst);
      a_req_op      = 2'(op);
      a_ext_wr_en   = (k == 0);
      a_ext_wr_sel  = 3'(esel);
      a_ext_wr_data = edata;
      @(posedge clk);
      #1;
      if (k == 0) model_write(esel, edata);
      sv      = m_regs[src];
      bus_exp = (op == 3) ? 8'h00 : sv;
      case (op)
         0: res = sv;
         1: res = sv + 8'd1;
         2: res = sv - 8'd1;
         default: res = 8'h00;
      endcase
      wrap = (op == 1 && sv == 8'hFF) || (op == 2 && sv == 8'h00);
      if (junk) begin
         a_req_src = 3'($urandom_range(0, 7));
         a_req_dst = 3'($urandom_range(0, 7));
         a_req_op  = 2'($urandom_range(0, 3));
      end else begin
         a_req_valid = 1'b0;
      end
      a_ext_wr_en = (k == 1);
      check_val("drive_ready", a_req_ready, 0);
      check_val("drive_done", a_done, 0);
      check_val("drive_bus", a_bus_data, bus_exp);
      @(posedge clk);
      #1;
      if (k == 1) model_write(esel, edata);
      a_ext_wr_en = (k == 2);
      check_val("latch_ready", a_req_ready, 0);
      check_val("latch_done", a_done, 1);
      check_val("latch_bus", a_bus_data, 0);
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      a_ext_wr_en = 1'b0;
      if (k == 2 && esel != dst) model_write(esel, edata);
      model_write(dst, res);
      if (op == 1 || op == 2) m_carry = wrap;
      check_val("post_done", a_done, 0);
      check_val("post_ready", a_req_ready, 1);
      check_val("post_carry", a_carry, m_carry);
      check_val("post_err", a_err, 0);
      check_all();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_carry = 1'b0;
      #3;
      do_reset();

      // MOV reg2 -> reg3
      ext_write(2, 8'h5A);
      xfer(2, 3, 0, 3, 0, 8'h00, 1'b0);
      a_rd_sel = 3'd3;
      #1;
      check_val("mov_r3", a_rd_data, 8'h5A);
      check_val("mov_carry", a_carry, 0);

      // INC wrap in place, then DEC wrap into reg4
      ext_write(1, 8'hFF);
      xfer(1, 1, 1, 3, 0, 8'h00, 1'b0);
      a_rd_sel = 3'd1;
      #1;
      check_val("inc_r1", a_rd_data, 8'h00);
      check_val("inc_carry", a_carry, 1);
      xfer(1, 4, 2, 3, 0, 8'h00, 1'b0);
      a_rd_sel = 3'd4;
      #1;
      check_val("dec_r4", a_rd_data, 8'hFF);
      check_val("dec_carry", a_carry, 1);

      // External write collides with CLR in the latch cycle
      ext_write(5, 8'h77);
      xfer(2, 5, 3, 2, 5, 8'h11, 1'b0);
      a_rd_sel = 3'd5;
      #1;
      check_val("clr_collide_r5", a_rd_data, 8'h00);

      // Register 0 behaviour
      ext_write(0, 8'h33);
      xfer(0, 6, 0, 3, 0, 8'h00, 1'b0);
      a_rd_sel = 3'd6;
      #1;
`ifdef BUS_XFER_ZERO_REG_EN
      check_val("zero_reg_r6", a_rd_data, 8'h00);
`else
      check_val("plain_reg0_r6", a_rd_data, 8'h33);
`endif

      // Out-of-range source on the six-register instance
      b_ext_wr_en   = 1'b1;
      b_ext_wr_sel  = 3'd1;
      b_ext_wr_data = 8'h77;
      @(posedge clk);
      #1;
      b_ext_wr_en = 1'b0;
      b_rd_sel    = 3'd1;
      #1;
      check_val("b_r1_pre", b_rd_data, 8'h77);
      check_val("b_err_pre", b_err, 0);
      b_req_valid = 1'b1;
      b_req_src   = 3'd7;
      b_req_dst   = 3'd1;
      b_req_op    = 2'd0;
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      check_val("b_err_set", b_err, 1);
      check_val("b_bus_oob", b_bus_data, 0);
      repeat (2) @(posedge clk);
      #1;
      check_val("b_r1_post", b_rd_data, 8'h00);
      repeat (5) @(posedge clk);
      #1;
      check_val("b_err_sticky", b_err, 1);
      b_rd_sel = 3'd7;
      #1;
      check_val("b_r7_reads0", b_rd_data, 8'h00);
      do_reset();
      check_val("b_err_cleared", b_err, 0);

      // Reset in the drive cycle aborts the transfer
      ext_write(2, 8'h5A);
      a_req_valid = 1'b1;
      a_req_src   = 3'd2;
      a_req_dst   = 3'd3;
      a_req_op    = 2'd0;
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_val("abort_done", a_done, 0);
      check_val("abort_ready", a_req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_val("abort_ready_after", a_req_ready, 1);
      check_val("abort_done_after", a_done, 0);
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_carry = 1'b0;
      @(posedge clk);
      #1;
      check_val("abort_done_late", a_done, 0);
      check_all();

      // Random transfers with concurrent external writes
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) ext_write($urandom_range(0, 7), 8'($urandom));
         xfer($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 7), 8'($urandom),
              1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
